// File: rtl/mv_select_pkg.sv
// mv_select_pkg: shared widths, block geometry and FSM state encoding for motion-vector selection.
package mv_select_pkg;
   localparam int BLK_SIZE  = 8;
   localparam int NUM_CAND  = BLK_SIZE * BLK_SIZE;
   localparam int SAD_W     = 8;
   localparam int MV_W      = 8;
   localparam int ZERO_BIAS = 4;
   localparam int CNT_W     = $clog2(NUM_CAND + 1);
   typedef logic [SAD_W-1:0]        sad_t;
   typedef logic signed [MV_W-1:0]  mv_t;
   typedef enum logic [1:0] {MVS_IDLE, MVS_COLLECT, MVS_HOLD} mvs_state_t;
endpackage

// File: rtl/mv_select_if.sv
// mv_select_if: candidate stream in, winning motion vector out on valid/ready, plus status flags.
interface mv_select_if;
   import mv_select_pkg::*;
   logic blk_start;
   logic cand_valid;
   sad_t cand_sad;
   mv_t  cand_mi;
   mv_t  cand_mj;
   logic best_valid;
   logic best_ready;
   sad_t best_sad;
   mv_t  best_mi;
   mv_t  best_mj;
   logic busy;
   logic err_overrun;
   modport master (output blk_start, cand_valid, cand_sad, cand_mi, cand_mj, best_ready,
                   input best_valid, best_sad, best_mi, best_mj, busy, err_overrun);
   modport slave  (input blk_start, cand_valid, cand_sad, cand_mi, cand_mj, best_ready,
                   output best_valid, best_sad, best_mi, best_mj, busy, err_overrun);
endinterface

// File: rtl/mv_cmp.sv
// mv_cmp: effective SAD of a candidate and whether it replaces the running best.
// Build option ZERO_MV_BIAS_EN credits the (0,0) vector with ZERO_BIAS, saturating at 0.
module mv_cmp
   import mv_select_pkg::*;
(
   input  sad_t cand_sad,
   input  mv_t  cand_mi,
   input  mv_t  cand_mj,
   input  sad_t run_min,
   input  logic first,
   output sad_t eff_sad,
   output logic update_en
);
`ifdef ZERO_MV_BIAS_EN
   always_comb eff_sad = (cand_mi == '0 && cand_mj == '0)
                       ? ((cand_sad > sad_t'(ZERO_BIAS)) ? cand_sad - sad_t'(ZERO_BIAS) : '0)
                       : cand_sad;
`else
   logic unused_mv;
   assign unused_mv = ^{cand_mi, cand_mj};
   assign eff_sad   = cand_sad;
`endif
   // The first candidate always loads, so an all-ones SAD can still win.
   assign update_en = first || (eff_sad < run_min);
endmodule

// File: rtl/mv_select.sv
// mv_select: tracks the minimum-SAD motion vector over one block and emits it on valid/ready.
// Build option ZERO_MV_BIAS_EN (in mv_cmp) favours the (0,0) vector in the comparison.
module mv_select
   import mv_select_pkg::*;
(
   input logic        clk,
   input logic        reset,
   mv_select_if.slave bus
);
   mvs_state_t       state;
   logic [CNT_W-1:0] cnt;
   sad_t             run_min, run_sad, eff_sad;
   mv_t              run_mi, run_mj;
   logic             update_en, last, handshake, restart, bad_input;
   sad_t             nxt_sad;
   mv_t              nxt_mi, nxt_mj;
   mv_cmp u_cmp (
      .cand_sad (bus.cand_sad),
      .cand_mi  (bus.cand_mi),
      .cand_mj  (bus.cand_mj),
      .run_min  (run_min),
      .first    (cnt == '0),
      .eff_sad  (eff_sad),
      .update_en(update_en)
   );
   assign last      = cnt == CNT_W'(NUM_CAND - 1);
   assign handshake = state == MVS_HOLD && bus.best_valid && bus.best_ready;
   assign restart   = bus.blk_start && (state != MVS_HOLD || handshake);
   assign bad_input = (state == MVS_IDLE && bus.cand_valid)
                   || (state == MVS_COLLECT && bus.blk_start)
                   || (state == MVS_HOLD && !handshake && (bus.blk_start || bus.cand_valid));
   assign nxt_sad   = update_en ? bus.cand_sad : run_sad;
   assign nxt_mi    = update_en ? bus.cand_mi : run_mi;
   assign nxt_mj    = update_en ? bus.cand_mj : run_mj;
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= MVS_IDLE;
         cnt             <= '0;
         run_min         <= '1;
         run_sad         <= '0;
         run_mi          <= '0;
         run_mj          <= '0;
         bus.best_valid  <= 1'b0;
         bus.best_sad    <= '0;
         bus.best_mi     <= '0;
         bus.best_mj     <= '0;
         bus.busy        <= 1'b0;
         bus.err_overrun <= 1'b0;
      end else begin
         bus.err_overrun <= bus.err_overrun | bad_input;
         if (restart) begin
            state          <= MVS_COLLECT;
            cnt            <= '0;
            run_min        <= '1;
            run_sad        <= '0;
            run_mi         <= '0;
            run_mj         <= '0;
            bus.best_valid <= 1'b0;
            bus.busy       <= 1'b1;
         end else if (state == MVS_COLLECT && bus.cand_valid) begin
            cnt <= cnt + 1'b1;
            if (update_en) begin
               run_min <= eff_sad;
               run_sad <= bus.cand_sad;
               run_mi  <= bus.cand_mi;
               run_mj  <= bus.cand_mj;
            end
            if (last) begin
               state          <= MVS_HOLD;
               bus.best_valid <= 1'b1;
               bus.best_sad   <= nxt_sad;
               bus.best_mi    <= nxt_mi;
               bus.best_mj    <= nxt_mj;
            end
         end else if (handshake) begin
            state          <= MVS_IDLE;
            bus.best_valid <= 1'b0;
            bus.busy       <= 1'b0;
         end
      end
   end
endmodule
